irrigation_sequencer: RTL and testbench

IRRIGATION_SEQUENCER -- requirements
Module: irrigation_sequencer

---
 rtl/irrigation_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_irrigation_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irrigation_sequencer.sv
// Irrigation sequencer: waits for a trusted event held for CONFIRM_TICKS,
// opens the valve for IRRIGATE_TICKS, then locks out for COOLDOWN_TICKS.
// Comparator fault codes are counted independently of the tick time base,
// and a sticky alarm blocks new cycles and aborts a watering in progress.
//
// Ports:
//   clk          single clock, rising edge
//   reset        synchronous, active-high reset
//   tick         one-cycle time-base strobe (1 tick = 100 s field time)
//   event_in     trusted event from the upstream sensor comparator
//   flag_in[2:0] comparator fault code (000 = none, else disagreeing sensor id)
//   alarm_clr    operator clear of fault_alarm and fault_count
//   valve_on     irrigation valve drive (high exactly while IRRIGATE)
//   state_out    00 IDLE, 01 CONFIRM, 10 IRRIGATE, 11 COOLDOWN
//   event_count  saturating count of completed irrigations
//   fault_count  saturating count of fault reports
//   last_fault   most recent nonzero fault code
//   fault_alarm  sticky alarm, raised when fault_count reaches FAULT_LIMIT
module irrigation_sequencer #(
  parameter int CONFIRM_TICKS  = 4,
  parameter int IRRIGATE_TICKS = 20,
  parameter int COOLDOWN_TICKS = 10,
  parameter int FAULT_LIMIT    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       event_in,
  input  logic [2:0] flag_in,
  input  logic       alarm_clr,
  output logic       valve_on,
  output logic [1:0] state_out,
  output logic [7:0] event_count,
  output logic [7:0] fault_count,
  output logic [2:0] last_fault,
  output logic       fault_alarm
);

  localparam int MAX_A     = (CONFIRM_TICKS > IRRIGATE_TICKS) ? CONFIRM_TICKS : IRRIGATE_TICKS;
  localparam int MAX_TICKS = (MAX_A > COOLDOWN_TICKS) ? MAX_A : COOLDOWN_TICKS;
  localparam int CNT_W     = $clog2(MAX_TICKS + 1);

  // A phase ends on the tick that would bring the counter to its limit.
  localparam logic [CNT_W-1:0] CONFIRM_LAST  = CNT_W'(CONFIRM_TICKS - 1);
  localparam logic [CNT_W-1:0] IRRIGATE_LAST = CNT_W'(IRRIGATE_TICKS - 1);
  localparam logic [CNT_W-1:0] COOLDOWN_LAST = CNT_W'(COOLDOWN_TICKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_CONFIRM  = 2'b01,
    ST_IRRIGATE = 2'b10,
    ST_COOLDOWN = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valve_on_q, valve_on_d;
  logic [7:0]       event_count_q, event_count_d;
  logic [7:0]       fault_count_q, fault_count_d;
  logic [2:0]       last_fault_q, last_fault_d;
  logic             fault_alarm_q, fault_alarm_d;
  logic [2:0]       flag_prev_q, flag_prev_d;
  logic             fault_edge;

  // ---------------------------------------------------------------------
  // Sequencer: advances only on ticks, except the alarm abort of IRRIGATE.
  // ---------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    event_count_d = event_count_q;

    unique case (state_q)
      ST_IDLE: begin
        if (tick && event_in && !fault_alarm_q) begin
          if (CONFIRM_TICKS <= 1) begin
            state_d = ST_IRRIGATE;
            cnt_d   = '0;
          end else begin
            state_d = ST_CONFIRM;
            cnt_d   = CNT_W'(1);
          end
        end
      end

      ST_CONFIRM: begin
        // A confirmation already under way is allowed to finish even if
        // the alarm rises; IRRIGATE then aborts on the following clk.
        if (tick) begin
          if (!event_in) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cnt_q >= CONFIRM_LAST) begin
            state_d = ST_IRRIGATE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_IRRIGATE: begin
        // Alarm abort wins over a coinciding final tick: no credit given.
        if (fault_alarm_q) begin
          state_d = ST_COOLDOWN;
          cnt_d   = '0;
        end else if (tick) begin
          if (cnt_q >= IRRIGATE_LAST) begin
            state_d = ST_COOLDOWN;
            cnt_d   = '0;
            if (event_count_q != 8'hFF) begin
              event_count_d = event_count_q + 8'd1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_COOLDOWN: begin
        if (tick) begin
          if (cnt_q >= COOLDOWN_LAST) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Registered from the next state so valve_on and state_out agree.
    valve_on_d = (state_d == ST_IRRIGATE);
  end

  // ---------------------------------------------------------------------
  // Fault tracking: runs every clk, independent of tick.
  // ---------------------------------------------------------------------
  // A fault is a 000 -> nonzero transition seen while no event is trusted;
  // the history follows flag_in every clk so a held code counts once, and a
  // code that rose while event_in=1 is never counted later.
  assign fault_edge = (flag_prev_q == 3'b000) && (flag_in != 3'b000) && !event_in;

  always_comb begin
    flag_prev_d   = flag_in;
    fault_count_d = fault_count_q;
    fault_alarm_d = fault_alarm_q;
    last_fault_d  = last_fault_q;

    if (fault_edge) begin
      last_fault_d = flag_in;
    end

    if (alarm_clr) begin
      fault_count_d = fault_edge ? 8'd1 : 8'd0;
      fault_alarm_d = 1'b0;
    end else if (fault_edge && (fault_count_q != 8'hFF)) begin
      fault_count_d = fault_count_q + 8'd1;
    end

    // Alarm is judged on the updated count so it rises with the counting
    // edge; after a clear this only fires when FAULT_LIMIT is 1.
    if (fault_edge && (int'(fault_count_d) >= FAULT_LIMIT)) begin
      fault_alarm_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      valve_on_q    <= 1'b0;
      event_count_q <= 8'd0;
      fault_count_q <= 8'd0;
      last_fault_q  <= 3'b000;
      fault_alarm_q <= 1'b0;
      flag_prev_q   <= 3'b000;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      valve_on_q    <= valve_on_d;
      event_count_q <= event_count_d;
      fault_count_q <= fault_count_d;
      last_fault_q  <= last_fault_d;
      fault_alarm_q <= fault_alarm_d;
      flag_prev_q   <= flag_prev_d;
    end
  end

  assign valve_on    = valve_on_q;
  assign state_out   = state_q;
  assign event_count = event_count_q;
  assign fault_count = fault_count_q;
  assign last_fault  = last_fault_q;
  assign fault_alarm = fault_alarm_q;

endmodule

// File: tb/tb_irrigation_sequencer.sv
// Directed bench for irrigation_sequencer with default parameters.
// Expected values are queued as stimulus is driven and compared once the
// DUT has responded (one clk later, sampled 1 time unit after the edge).
module tb_irrigation_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       event_in;
  logic [2:0] flag_in;
  logic       alarm_clr;
  logic       valve_on;
  logic [1:0] state_out;
  logic [7:0] event_count;
  logic [7:0] fault_count;
  logic [2:0] last_fault;
  logic       fault_alarm;

  localparam logic [1:0] IDLE     = 2'b00;
  localparam logic [1:0] CONFIRM  = 2'b01;
  localparam logic [1:0] IRRIGATE = 2'b10;
  localparam logic [1:0] COOLDOWN = 2'b11;

  always #5 clk = ~clk;

  irrigation_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .event_in   (event_in),
    .flag_in    (flag_in),
    .alarm_clr  (alarm_clr),
    .valve_on   (valve_on),
    .state_out  (state_out),
    .event_count(event_count),
    .fault_count(fault_count),
    .last_fault (last_fault),
    .fault_alarm(fault_alarm)
  );

  typedef enum int {S_VALVE, S_STATE, S_EVCNT, S_FCNT, S_LAST, S_ALARM, S_VCYC} sel_e;

  typedef struct {
    string       tag;
    sel_e        sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_compared   = 0;
  int   n_mismatched = 0;
  int   valve_cycles = 0;

  function automatic logic [31:0] observe(sel_e s);
    case (s)
      S_VALVE: return {31'd0, valve_on};
      S_STATE: return {30'd0, state_out};
      S_EVCNT: return {24'd0, event_count};
      S_FCNT:  return {24'd0, fault_count};
      S_LAST:  return {29'd0, last_fault};
      S_ALARM: return {31'd0, fault_alarm};
      default: return valve_cycles;
    endcase
  endfunction

  task automatic expect_val(input string tag, input sel_e sel, input logic [31:0] exp);
    sb_q.push_back('{tag, sel, exp});
  endtask

  // Pops every queued expectation and compares it with the DUT now.
  task automatic check();
    exp_t        e;
    logic [31:0] obs;
    while (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      obs = observe(e.sel);
      n_compared++;
      assert (obs === e.exp)
      else begin
        n_mismatched++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
      end
    end
  endtask

  // One clk: drive inputs, take the edge, settle, tally valve-on cycles.
  task automatic cyc(input logic t, input logic ev, input logic [2:0] fl,
                     input logic clr, input logic rst);
    tick      = t;
    event_in  = ev;
    flag_in   = fl;
    alarm_clr = clr;
    reset     = rst;
    @(posedge clk);
    #1;
    if (valve_on === 1'b1) valve_cycles++;
  endtask

  // One tick period of 4 clk, strobe on the last clk.
  task automatic tk(input logic ev);
    repeat (3) cyc(1'b0, ev, 3'b000, 1'b0, 1'b0);
    cyc(1'b1, ev, 3'b000, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b0, 3'b000, 1'b0, 1'b1);
    valve_cycles = 0;
  endtask

  task automatic expect_reset_vals(input string tag);
    expect_val({tag, "_valve"}, S_VALVE, 0);
    expect_val({tag, "_state"}, S_STATE, IDLE);
    expect_val({tag, "_evcnt"}, S_EVCNT, 0);
    expect_val({tag, "_fcnt"},  S_FCNT,  0);
    expect_val({tag, "_last"},  S_LAST,  0);
    expect_val({tag, "_alarm"}, S_ALARM, 0);
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; event_in = 1'b0; flag_in = 3'b000; alarm_clr = 1'b0;

    // Reset overrides tick, event_in and alarm_clr.
    cyc(1'b1, 1'b1, 3'b000, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 3'b000, 1'b1, 1'b1);
    expect_reset_vals("rst");
    check();

    // Full watering cycle, tick every 4 clk.
    do_reset();
    tk(1'b1);
    expect_val("s1_confirm1", S_STATE, CONFIRM);
    check();
    tk(1'b1);
    tk(1'b1);
    expect_val("s1_confirm3", S_STATE, CONFIRM);
    expect_val("s1_valve_c3", S_VALVE, 0);
    check();
    tk(1'b1);
    expect_val("s1_irrigate", S_STATE, IRRIGATE);
    expect_val("s1_valve_on", S_VALVE, 1);
    check();
    for (int i = 1; i <= 20; i++) begin
      tk(1'b0);
      if (i == 19) begin
        expect_val("s1_irr19_state", S_STATE, IRRIGATE);
        expect_val("s1_irr19_valve", S_VALVE, 1);
        check();
      end
    end
    expect_val("s1_cool_state", S_STATE, COOLDOWN);
    expect_val("s1_cool_valve", S_VALVE, 0);
    expect_val("s1_evcnt", S_EVCNT, 1);
    check();
    for (int i = 1; i <= 10; i++) begin
      tk(1'b1);
      if (i == 9) begin
        expect_val("s1_cool9", S_STATE, COOLDOWN);
        check();
      end
    end
    expect_val("s1_idle", S_STATE, IDLE);
    expect_val("s1_valve_cycles", S_VCYC, 80);
    expect_val("s1_evcnt_end", S_EVCNT, 1);
    check();

    // Event drops on the 4th tick: no watering.
    do_reset();
    tk(1'b1);
    tk(1'b1);
    tk(1'b1);
    expect_val("s2_confirm", S_STATE, CONFIRM);
    check();
    tk(1'b0);
    expect_val("s2_idle", S_STATE, IDLE);
    expect_val("s2_valve_cycles", S_VCYC, 0);
    expect_val("s2_evcnt", S_EVCNT, 0);
    check();

    // Fault counting, alarm, blocking, clear.
    do_reset();
    cyc(1'b0, 1'b1, 3'b011, 1'b0, 1'b0);
    expect_val("s3_ign_fcnt", S_FCNT, 0);
    expect_val("s3_ign_last", S_LAST, 0);
    check();
    cyc(1'b0, 1'b0, 3'b011, 1'b0, 1'b0);
    expect_val("s3_held_fcnt", S_FCNT, 0);
    check();
    cyc(1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      cyc(1'b0, 1'b0, 3'b010, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 3'b010, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
      expect_val("s3_fcnt", S_FCNT, k);
      if (k == 2) expect_val("s3_alarm_k2", S_ALARM, 0);
      check();
    end
    expect_val("s3_last", S_LAST, 3'b010);
    expect_val("s3_alarm", S_ALARM, 1);
    check();
    valve_cycles = 0;
    repeat (4) tk(1'b1);
    expect_val("s3_blocked_state", S_STATE, IDLE);
    expect_val("s3_blocked_valve", S_VCYC, 0);
    check();
    cyc(1'b0, 1'b0, 3'b000, 1'b1, 1'b0);
    expect_val("s3_clr_alarm", S_ALARM, 0);
    expect_val("s3_clr_fcnt", S_FCNT, 0);
    expect_val("s3_clr_last", S_LAST, 3'b010);
    check();

    // Alarm reached at IRRIGATE tick 7 aborts on the next clk.
    do_reset();
    repeat (4) tk(1'b1);
    repeat (6) tk(1'b0);
    cyc(1'b0, 1'b0, 3'b001, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 3'b001, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
    expect_val("s4_fcnt2", S_FCNT, 2);
    expect_val("s4_state_pre", S_STATE, IRRIGATE);
    check();
    cyc(1'b1, 1'b0, 3'b001, 1'b0, 1'b0);
    expect_val("s4_alarm", S_ALARM, 1);
    expect_val("s4_state_t7", S_STATE, IRRIGATE);
    expect_val("s4_valve_t7", S_VALVE, 1);
    check();
    cyc(1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
    expect_val("s4_abort_state", S_STATE, COOLDOWN);
    expect_val("s4_abort_valve", S_VALVE, 0);
    expect_val("s4_abort_evcnt", S_EVCNT, 0);
    check();

    // Reset at IRRIGATE tick 5 with a fault code held across it.
    do_reset();
    repeat (4) tk(1'b1);
    repeat (4) tk(1'b0);
    expect_val("s5_pre_valve", S_VALVE, 1);
    check();
    repeat (3) cyc(1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 3'b001, 1'b0, 1'b1);
    expect_reset_vals("s5_rst");
    check();
    cyc(1'b0, 1'b0, 3'b001, 1'b0, 1'b0);
    expect_val("s5_fcnt", S_FCNT, 1);
    expect_val("s5_last", S_LAST, 3'b001);
    check();
    cyc(1'b0, 1'b0, 3'b001, 1'b0, 1'b0);
    expect_val("s5_fcnt_held", S_FCNT, 1);
    check();

    // event_count saturation, tick every clk (34 clk per irrigation).
    do_reset();
    repeat (34) cyc(1'b1, 1'b1, 3'b000, 1'b0, 1'b0);
    expect_val("s6_evcnt1", S_EVCNT, 1);
    check();
    repeat (254 * 34) cyc(1'b1, 1'b1, 3'b000, 1'b0, 1'b0);
    expect_val("s6_evcnt255", S_EVCNT, 255);
    expect_val("s6_idle255", S_STATE, IDLE);
    check();
    repeat (34) cyc(1'b1, 1'b1, 3'b000, 1'b0, 1'b0);
    expect_val("s6_evcnt_sat", S_EVCNT, 255);
    expect_val("s6_idle256", S_STATE, IDLE);
    check();

    // alarm_clr coincident with a fault edge.
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b0, 3'b100, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
    end
    expect_val("s6_alarm_set", S_ALARM, 1);
    expect_val("s6_fcnt3", S_FCNT, 3);
    check();
    cyc(1'b0, 1'b0, 3'b100, 1'b1, 1'b0);
    expect_val("s6_clr_fcnt", S_FCNT, 1);
    expect_val("s6_clr_alarm", S_ALARM, 0);
    expect_val("s6_clr_last", S_LAST, 3'b100);
    check();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
